// File: rtl/abr_ram_stream_rd.sv
// Read-side streaming engine: walks a wrap-around word range of a 1R1W RAM and
// presents each word on a valid/ready stream through a 2-entry output FIFO.
module abr_ram_stream_rd #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 32,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   num_words_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  ram_re_o,
    output logic [ADDR_WIDTH-1:0] ram_raddr_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i,
    output logic                  data_valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_last_o,
    input  logic                  data_ready_i
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH:0]   issue_cnt;
    logic [ADDR_WIDTH:0]   pop_cnt;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            fifo_occ;
    logic [2:0]            fill;
    logic                  pop;

    // Credits: a pop in this cycle frees a slot for an issue in the same cycle.
    assign pop          = data_valid_o && data_ready_i;
    assign fill         = {1'b0, fifo_occ} + {2'b00, inflight};
    assign ram_re_o     = (state == RUN) && (issue_cnt != '0) && (fill < (3'd2 + {2'b00, pop}));
    assign ram_raddr_o  = rd_addr;

    assign data_valid_o = (fifo_occ != 2'd0);
    assign data_last_o  = data_valid_o && (pop_cnt == CNT_ONE);
    // NOTE: the FIFO storage is not reset; data_o is forced to zero while empty instead.
    assign data_o       = data_valid_o ? fifo_mem[rd_ptr] : '0;

    assign busy_o       = (state == RUN);
    assign done_o       = (state == DONE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            rd_addr   <= '0;
            issue_cnt <= '0;
            pop_cnt   <= '0;
            inflight  <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            fifo_occ  <= 2'd0;
        end else begin
            inflight <= ram_re_o;
            fifo_occ <= fifo_occ + {1'b0, inflight} - {1'b0, pop};
            if (inflight) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                pop_cnt <= pop_cnt - CNT_ONE;
            end
            if (ram_re_o) begin
                issue_cnt <= issue_cnt - CNT_ONE;
                rd_addr   <= (rd_addr == ADDR_LAST) ? '0 : rd_addr + ADDR_ONE;
            end

            case (state)
                IDLE: begin
                    if (start_i) begin
                        rd_addr   <= base_addr_i;
                        issue_cnt <= num_words_i;
                        pop_cnt   <= num_words_i;
                        state     <= (num_words_i == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (pop && (pop_cnt == CNT_ONE)) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Returned read data lands at the FIFO tail; a write during reset is dropped by the cleared occupancy.
    always_ff @(posedge clk_i) begin
        if (inflight) begin
            fifo_mem[wr_ptr] <= ram_rdata_i;
        end
    end

endmodule

// File: tb/tb_abr_ram_stream_rd.sv
// Randomized bench for abr_ram_stream_rd: two instances (DEPTH 64 and 48) checked
// against the expected word sequence mem[(base+i) mod DEPTH], i = 0..num-1.
module tb_abr_ram_stream_rd;

    localparam int DW = 32;
    localparam int AW = 6;

    typedef struct {
        int            d;
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } pop_t;

    typedef struct {
        int d;
        int addr;
    } iss_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [1:0]    start;
    logic [1:0]    busy;
    logic [1:0]    done;
    logic [1:0]    re;
    logic [1:0]    valid;
    logic [1:0]    last;
    logic          ready;
    logic [AW-1:0] base  [2];
    logic [AW:0]   num   [2];
    logic [AW-1:0] raddr [2];
    logic [DW-1:0] rdata [2];
    logic [DW-1:0] dout  [2];
    logic [DW-1:0] mem   [2][64];

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    pop_t pops[$];
    iss_t iss[$];
    int   n_done     [2] = '{0, 0};
    int   out_cnt    [2] = '{0, 0};
    bit   prev_stall [2] = '{0, 0};
    logic [DW-1:0] prev_data [2];

    always #5 clk_i = ~clk_i;

    abr_ram_stream_rd #(.DEPTH(64), .DATA_WIDTH(DW)) u_dut64 (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start[0]),
        .base_addr_i  (base[0]),
        .num_words_i  (num[0]),
        .busy_o       (busy[0]),
        .done_o       (done[0]),
        .ram_re_o     (re[0]),
        .ram_raddr_o  (raddr[0]),
        .ram_rdata_i  (rdata[0]),
        .data_valid_o (valid[0]),
        .data_o       (dout[0]),
        .data_last_o  (last[0]),
        .data_ready_i (ready)
    );

    abr_ram_stream_rd #(.DEPTH(48), .DATA_WIDTH(DW)) u_dut48 (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start[1]),
        .base_addr_i  (base[1]),
        .num_words_i  (num[1]),
        .busy_o       (busy[1]),
        .done_o       (done[1]),
        .ram_re_o     (re[1]),
        .ram_raddr_o  (raddr[1]),
        .ram_rdata_i  (rdata[1]),
        .data_valid_o (valid[1]),
        .data_o       (dout[1]),
        .data_last_o  (last[1]),
        .data_ready_i (ready)
    );

    // RAM models with one-cycle read latency.
    always @(posedge clk_i) begin
        for (int d = 0; d < 2; d++) begin
            if (re[d]) rdata[d] <= mem[d][raddr[d]];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int depth_of(input int d);
        return (d == 0) ? 64 : 48;
    endfunction

    // Stream monitor: records issues and pops, checks credits and stall stability.
    always @(negedge clk_i) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (rst_i) begin
                out_cnt[d]    <= 0;
                prev_stall[d] <= 1'b0;
            end else begin
                if (re[d]) begin
                    iss.push_back('{d, int'(raddr[d])});
                    check("credit", 64'((out_cnt[d] - int'(valid[d] && ready)) < 2), 64'd1);
                end
                if (valid[d] && ready) pops.push_back('{d, dout[d], last[d], cyc});
                if (prev_stall[d]) begin
                    check("hold_valid", 64'(valid[d]), 64'd1);
                    check("hold_data", 64'(dout[d]), 64'(prev_data[d]));
                end
                if (done[d]) begin
                    n_done[d] <= n_done[d] + 1;
                    check("busy_at_done", 64'(busy[d]), 64'd0);
                end
                out_cnt[d]    <= out_cnt[d] + int'(re[d]) - int'(valid[d] && ready);
                prev_stall[d] <= valid[d] && !ready;
                prev_data[d]  <= dout[d];
            end
        end
    end

    task automatic check_reset_outputs(input int d);
        check("rst_busy",  64'(busy[d]),  64'd0);
        check("rst_done",  64'(done[d]),  64'd0);
        check("rst_re",    64'(re[d]),    64'd0);
        check("rst_raddr", 64'(raddr[d]), 64'd0);
        check("rst_valid", 64'(valid[d]), 64'd0);
        check("rst_last",  64'(last[d]),  64'd0);
        check("rst_data",  64'(dout[d]),  64'd0);
    endtask

    // One command: d selects the instance; pct is the ready probability;
    // restart_at pulses a second start inside the run; abort_at applies reset mid-run.
    task automatic run_cmd(input int d, input int b, input int n, input int pct,
                           input int restart_at, input int abort_at);
        int depth = depth_of(d);
        int nd0;
        int exp_a;
        int m;
        iss.delete();
        pops.delete();
        nd0 = n_done[d];
        @(posedge clk_i); #1;
        start[d] = 1'b1;
        base[d]  = AW'(b);
        num[d]   = (AW + 1)'(n);
        ready    = ($urandom_range(99) < pct);
        @(posedge clk_i); #1;
        start[d] = 1'b0;
        base[d]  = AW'($urandom_range(depth - 1));
        num[d]   = (AW + 1)'($urandom_range(depth));
        @(negedge clk_i);
        check("busy_t1", 64'(busy[d]), 64'(n != 0));
        check("done_t1", 64'(done[d]), 64'(n == 0));
        check("re_t1",   64'(re[d]),   64'(n != 0));
        if (n != 0) begin
            @(negedge clk_i);
            @(negedge clk_i);
            check("valid_t3", 64'(valid[d]), 64'd1);
        end
        #1;
        for (int k = 0; k < 4000 && n_done[d] == nd0; k++) begin
            @(posedge clk_i); #1;
            start[d] = (k == restart_at);
            ready    = ($urandom_range(99) < pct);
            if (k == abort_at) begin
                rst_i = 1'b1;
                @(posedge clk_i); #1;
                start[d] = 1'b0;
                @(negedge clk_i);
                check_reset_outputs(d);
                #1 rst_i = 1'b0;
                return;
            end
            @(negedge clk_i); #1;
        end
        start[d] = 1'b0;
        check("done_seen", 64'(n_done[d] != nd0), 64'd1);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i); #1;
        check("done_count", 64'(n_done[d] - nd0), 64'd1);
        check("n_issue", 64'(iss.size()), 64'(n));
        check("n_pop",   64'(pops.size()), 64'(n));
        m = (pops.size() < n) ? pops.size() : n;
        for (int i = 0; i < n && i < iss.size(); i++) begin
            exp_a = (b + i) % depth;
            check("iss_addr", {iss[i].d, iss[i].addr}, {d, exp_a});
        end
        for (int i = 0; i < m; i++) begin
            exp_a = (b + i) % depth;
            check("pop_dut",  64'(pops[i].d),    64'(d));
            check("pop_data", 64'(pops[i].data), 64'(mem[d][exp_a]));
            check("pop_last", 64'(pops[i].last), 64'(i == n - 1));
            if (pct == 100) check("no_bubble", 64'(pops[i].cyc - pops[0].cyc), 64'(i));
        end
    endtask

    initial begin
        int d;
        int depth;
        rst_i = 1'b1;
        start = 2'b00;
        ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            base[k] = '0;
            num[k]  = '0;
        end
        for (int i = 0; i < 64; i++) begin
            mem[0][i] = 32'(i * 32'h11);
            mem[1][i] = $urandom;
        end
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_reset_outputs(0);
        check_reset_outputs(1);
        #1 rst_i = 1'b0;

        run_cmd(0, 5, 4, 100, -1, -1);      // basic: 0x55..0x88
        run_cmd(0, 0, 8, 50, -1, -1);       // backpressure
        run_cmd(0, 62, 4, 100, -1, -1);     // wrap at 64
        run_cmd(1, 46, 4, 100, -1, -1);     // wrap at 48
        run_cmd(0, 0, 0, 100, -1, -1);      // zero length
        run_cmd(0, 9, 64, 100, -1, -1);     // full length, full rate
        run_cmd(0, 33, 64, 40, -1, -1);     // full length under backpressure
        run_cmd(0, 0, 8, 0, -1, 0);         // reset with the FIFO full
        run_cmd(0, 17, 12, 60, -1, -1);     // clean command after reset
        run_cmd(0, 10, 20, 70, 3, -1);      // start while busy is ignored
        run_cmd(1, 40, 48, 100, -1, -1);    // full length on DEPTH=48

        for (int t = 0; t < 8; t++) begin
            d     = int'($urandom_range(1));
            depth = depth_of(d);
            for (int i = 0; i < 64; i++) mem[d][i] = $urandom;
            run_cmd(d, int'($urandom_range(depth - 1)), int'($urandom_range(depth)),
                    int'($urandom_range(30, 100)), -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
